// File: rtl/pkt_merge_arbiter_pkg.sv
// pkt_merge_arbiter_pkg: shared word format, tag encodings, sizing and FSM states for the packet merge arbiter
package pkt_merge_arbiter_pkg;
  localparam int W_PKT = 134;
  localparam int FIFO_AW = 8;
  localparam int MAX_PKT_WORDS = 100;
  typedef enum logic [1:0] {TAG_HEAD = 2'b01, TAG_TAIL = 2'b10, TAG_BODY = 2'b11} tag_t;
  typedef enum logic [1:0] {IDLE, SEND0, SEND1} state_t;
  function automatic logic is_tail(input logic [W_PKT-1:0] w);
    return w[W_PKT-1 -: 2] == TAG_TAIL;
  endfunction
endpackage

// File: rtl/pkt_merge_arbiter_if.sv
// pkt_merge_arbiter_if: two packet inputs (wr/data/ready), merged output (wr/data/ready), per-input packet counts and sticky overflow flags
interface pkt_merge_arbiter_if import pkt_merge_arbiter_pkg::*; ();
  logic pkt0_data_wr;
  logic [W_PKT-1:0] pkt0_data;
  logic pkt0_ready;
  logic pkt1_data_wr;
  logic [W_PKT-1:0] pkt1_data;
  logic pkt1_ready;
  logic pktout_data_wr;
  logic [W_PKT-1:0] pktout_data;
  logic pktout_ready;
  logic [31:0] pkt0_cnt;
  logic [31:0] pkt1_cnt;
  logic [1:0] ovf_err;
  modport master (
    output pkt0_data_wr, pkt0_data, pkt1_data_wr, pkt1_data, pktout_ready,
    input pkt0_ready, pkt1_ready, pktout_data_wr, pktout_data, pkt0_cnt, pkt1_cnt, ovf_err
  );
  modport slave (
    input pkt0_data_wr, pkt0_data, pkt1_data_wr, pkt1_data, pktout_ready,
    output pkt0_ready, pkt1_ready, pktout_data_wr, pktout_data, pkt0_cnt, pkt1_cnt, ovf_err
  );
endinterface

// File: rtl/pkt_sync_fifo.sv
// pkt_sync_fifo: show-ahead sync FIFO; ports clk/reset, wr/din write (dropped when full), rd/dout pop, full/empty flags, registered count
module pkt_sync_fifo #(
  parameter int W = 8,
  parameter int AW = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic wr,
  input  logic [W-1:0] din,
  input  logic rd,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [AW:0] count
);
  logic [W-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic do_wr, do_rd;
  assign full = count[AW];
  assign empty = count == '0;
  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_wr) mem[wp] <= din;
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_wr);
      rp <= rp + AW'(do_rd);
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
endmodule

// File: rtl/pkt_merge_arbiter.sv
// pkt_merge_arbiter: packet-atomic 2:1 round-robin merge; ports clk, reset, bus (inputs 0/1, merged output, counters, overflow flags)
module pkt_merge_arbiter import pkt_merge_arbiter_pkg::*; (
  input logic clk,
  input logic reset,
  pkt_merge_arbiter_if.slave bus
);
  localparam int CW = FIFO_AW + 1;
  logic [1:0] wr_in, full, empty, pop, w_tail, r_tail, elig, rdy, ovf;
  logic [W_PKT-1:0] din [2];
  logic [W_PKT-1:0] q [2];
  logic [CW-1:0] cnt [2];
  logic [CW-1:0] cpkt [2];
  logic pick1, rr_last;
  state_t state, state_nx;
  assign wr_in = {bus.pkt1_data_wr, bus.pkt0_data_wr};
  assign din[0] = bus.pkt0_data;
  assign din[1] = bus.pkt1_data;
  for (genvar i = 0; i < 2; i++) begin : g_in
    pkt_sync_fifo #(.W(W_PKT), .AW(FIFO_AW)) u_fifo (
      .clk(clk), .reset(reset), .wr(wr_in[i]), .din(din[i]), .rd(pop[i]),
      .dout(q[i]), .full(full[i]), .empty(empty[i]), .count(cnt[i])
    );
    assign w_tail[i] = wr_in[i] & ~full[i] & is_tail(din[i]);
    assign r_tail[i] = pop[i] & is_tail(q[i]);
    assign elig[i] = cpkt[i] != '0;
  end
  assign pop = {state == SEND1 & ~empty[1], state == SEND0 & ~empty[0]};
  assign bus.pkt0_ready = rdy[0];
  assign bus.pkt1_ready = rdy[1];
  assign bus.ovf_err = ovf;
  always_comb begin
    pick1 = elig[1] & (~elig[0] | ~rr_last);
    state_nx = state == IDLE ? (bus.pktout_ready && |elig ? (pick1 ? SEND1 : SEND0) : IDLE)
                             : (|r_tail ? IDLE : state);
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      rr_last <= 1'b1;
      bus.pktout_data_wr <= 1'b0;
      bus.pktout_data <= '0;
      bus.pkt0_cnt <= '0;
      bus.pkt1_cnt <= '0;
      rdy <= '0;
      ovf <= '0;
      cpkt[0] <= '0;
      cpkt[1] <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx != IDLE) rr_last <= pick1;
      bus.pktout_data_wr <= |pop;
      if (|pop) bus.pktout_data <= pop[1] ? q[1] : q[0];
      bus.pkt0_cnt <= bus.pkt0_cnt + 32'(r_tail[0]);
      bus.pkt1_cnt <= bus.pkt1_cnt + 32'(r_tail[1]);
      for (int i = 0; i < 2; i++) begin
        cpkt[i] <= cpkt[i] + CW'(w_tail[i]) - CW'(r_tail[i]);
        rdy[i] <= CW'(2 ** FIFO_AW) - cnt[i] >= CW'(MAX_PKT_WORDS);
        ovf[i] <= ovf[i] | (wr_in[i] & full[i]);
      end
    end
endmodule
